pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_pkg.sv | 16 +
 rtl/pc_ras.sv | 72 +++++++
 rtl/pc_unit.sv | 104 ++++++++++
 tb/tb_pc_unit.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: next-pc source encoding
// and the sequential increment.
package pc_pkg;

  typedef enum logic [2:0] {
    SRC_RESET,
    SRC_TRAP,
    SRC_REDIRECT,
    SRC_RAS,
    SRC_SEQ,
    SRC_HOLD
  } pc_src_e;

  localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. When full, a push overwrites the oldest
// entry and the count saturates at DEPTH. A simultaneous push and pop
// replaces the top entry and leaves the count unchanged.
module pc_ras
  import pc_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [XLEN-1:0]            push_data,
  output logic [XLEN-1:0]            top,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] mem [DEPTH];
  logic [AW-1:0]   sp;
  logic [AW-1:0]   top_idx;
  logic [CW-1:0]   cnt;
  logic            do_pop;
  logic            wr_en;
  logic [AW-1:0]   wr_idx;

  assign top_idx = sp - AW'(1);
  assign do_pop  = pop && (cnt != '0);
  assign top     = mem[top_idx];
  assign empty   = (cnt == '0);
  assign count   = cnt;

  // Write slot: replace the top on push+pop, otherwise append at sp.
  always_comb begin
    wr_en  = push;
    wr_idx = sp;
    if (push && do_pop) begin
      wr_idx = top_idx;
    end
  end

  // Entry storage needs no reset; validity is tracked by cnt.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= push_data;
    end
  end

  // Stack pointer and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp  <= '0;
      cnt <= '0;
    end else if (push && do_pop) begin
      sp  <= sp;
      cnt <= cnt;
    end else if (push) begin
      sp <= sp + AW'(1);
      if (cnt != CW'(DEPTH)) begin
        cnt <= cnt + CW'(1);
      end
    end else if (do_pop) begin
      sp  <= sp - AW'(1);
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit with reset/trap/redirect/return/sequential priority.
// Optional return-address stack is enabled by defining PC_UNIT_RAS_EN;
// without it, is_call/is_ret are ignored and ras_empty is tied high.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            fetch_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap,
  input  logic            is_call,
  input  logic            is_ret,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic            pc_misaligned,
  output logic            ras_empty
);

  logic            accept;
  logic            ret_hit;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] ras_top;
  logic [XLEN-1:0] next_pc;
  pc_src_e         src;

  assign accept = pc_valid && fetch_ready && !stall;
  assign seq_pc = pc + XLEN'(PC_INC);

`ifdef PC_UNIT_RAS_EN
  logic                           ras_push;
  logic                           ras_pop;
  logic [$clog2(RAS_DEPTH+1)-1:0] unused_ras_count;

  // Stack updates are suppressed whenever trap or redirect steers the pc.
  assign ras_push = accept && is_call && !trap && !redirect_valid;
  assign ras_pop  = accept && is_ret && !ras_empty && !trap && !redirect_valid;
  assign ret_hit  = accept && is_ret && !ras_empty;

  pc_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (seq_pc),
    .top       (ras_top),
    .empty     (ras_empty),
    .count     (unused_ras_count)
  );
`else
  logic unused_ras_inputs;

  assign unused_ras_inputs = ^{is_call, is_ret};
  assign ret_hit           = 1'b0;
  assign ras_top           = '0;
  assign ras_empty         = 1'b1;
`endif

  // Select the next-pc source by fixed priority and form its value.
  always_comb begin
    src     = SRC_HOLD;
    next_pc = pc;
    if (rst) begin
      src     = SRC_RESET;
      next_pc = RESET_VECTOR;
    end else if (trap) begin
      src     = SRC_TRAP;
      next_pc = TRAP_VECTOR;
    end else if (redirect_valid) begin
      src     = SRC_REDIRECT;
      next_pc = {redirect_target[XLEN-1:2], 2'b00};
    end else if (ret_hit) begin
      src     = SRC_RAS;
      next_pc = ras_top;
    end else if (accept) begin
      src     = SRC_SEQ;
      next_pc = seq_pc;
    end
  end

  // Registered pc, validity and one-cycle misalignment flag.
  always_ff @(posedge clk) begin
    if (src == SRC_RESET) begin
      pc            <= RESET_VECTOR;
      pc_valid      <= 1'b0;
      pc_misaligned <= 1'b0;
    end else begin
      pc            <= next_pc;
      pc_valid      <= 1'b1;
      pc_misaligned <= (src == SRC_REDIRECT) && (redirect_target[1:0] != 2'b00);
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit; RAS checks are compiled when
// PC_UNIT_RAS_EN is defined, otherwise the RAS-disabled behaviour is checked.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        fetch_ready;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        trap;
  logic        is_call;
  logic        is_ret;
  logic [31:0] pc;
  logic        pc_valid;
  logic        pc_misaligned;
  logic        ras_empty;

  int unsigned errors = 0;
  int unsigned checks = 0;

  pc_unit #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0000_0000),
    .TRAP_VECTOR  (32'h0000_0100),
    .RAS_DEPTH    (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .fetch_ready     (fetch_ready),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .trap            (trap),
    .is_call         (is_call),
    .is_ret          (is_ret),
    .pc              (pc),
    .pc_valid        (pc_valid),
    .pc_misaligned   (pc_misaligned),
    .ras_empty       (ras_empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst             = 1'b0;
    stall           = 1'b0;
    fetch_ready     = 1'b1;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    trap            = 1'b0;
    is_call         = 1'b0;
    is_ret          = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic redirect_to(input logic [31:0] tgt);
    redirect_valid  = 1'b1;
    redirect_target = tgt;
    step();
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
  endtask

  logic [31:0] seq_exp [5];
  logic [31:0] ret_exp [5];
  logic        emp_exp [5];

  initial begin
    seq_exp = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};

    // Reset, then sequential advance
    do_reset();
    check("reset_pc", pc, 32'h0);
    check("reset_valid", 32'(pc_valid), 32'h0);
    check("reset_misaligned", 32'(pc_misaligned), 32'h0);
    check("reset_ras_empty", 32'(ras_empty), 32'h1);
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("seq_pc%0d", i), pc, seq_exp[i]);
      check($sformatf("seq_valid%0d", i), 32'(pc_valid), 32'h1);
    end

    // Stall at 0x8, then redirect during stall
    do_reset();
    step(); step(); step();
    check("pre_stall_pc", pc, 32'h8);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("stall_hold%0d", i), pc, 32'h8);
    end
    redirect_to(32'h40);
    check("stall_redirect_pc", pc, 32'h40);
    check("stall_redirect_mis", 32'(pc_misaligned), 32'h0);
    stall = 1'b0;

    // fetch_ready low holds pc
    fetch_ready = 1'b0;
    step();
    check("not_ready_hold", pc, 32'h40);
    fetch_ready = 1'b1;

    // Trap beats redirect
    trap = 1'b1;
    redirect_to(32'h80);
    trap = 1'b0;
    check("trap_over_redirect_pc", pc, 32'h100);
    check("trap_over_redirect_mis", 32'(pc_misaligned), 32'h0);

    // Misaligned redirect: target forced aligned, flag for one cycle
    redirect_to(32'h42);
    check("misaligned_pc", pc, 32'h40);
    check("misaligned_flag", 32'(pc_misaligned), 32'h1);
    step();
    check("misaligned_after_pc", pc, 32'h44);
    check("misaligned_cleared", 32'(pc_misaligned), 32'h0);

    // Misaligned redirect overridden by trap does not flag
    trap = 1'b1;
    redirect_to(32'h43);
    trap = 1'b0;
    check("trap_mis_pc", pc, 32'h100);
    check("trap_mis_flag", 32'(pc_misaligned), 32'h0);

    // Wrap at the top of the address space
    redirect_to(32'hFFFF_FFFC);
    check("wrap_pre", pc, 32'hFFFF_FFFC);
    step();
    check("wrap_post", pc, 32'h0000_0000);

    // Reset mid-operation overrides trap/redirect/call/ret
    step(); step();
    rst             = 1'b1;
    trap            = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'h42;
    is_call         = 1'b1;
    is_ret          = 1'b1;
    step();
    check("midrst_pc", pc, 32'h0);
    check("midrst_valid", 32'(pc_valid), 32'h0);
    check("midrst_mis", 32'(pc_misaligned), 32'h0);
    check("midrst_ras_empty", 32'(ras_empty), 32'h1);
    idle_inputs();
    step();
    check("midrst_release_pc", pc, 32'h0);
    check("midrst_release_valid", 32'(pc_valid), 32'h1);

`ifdef PC_UNIT_RAS_EN
    // Call at 0x10, redirect away, return
    do_reset();
    for (int i = 0; i < 5; i++) step();
    check("ras_pre_call_pc", pc, 32'h10);
    is_call = 1'b1; step(); is_call = 1'b0;
    check("ras_call_pc", pc, 32'h14);
    check("ras_call_nonempty", 32'(ras_empty), 32'h0);
    redirect_to(32'h200);
    check("ras_redirect_pc", pc, 32'h200);
    is_ret = 1'b1; step(); is_ret = 1'b0;
    check("ras_ret_pc", pc, 32'h14);
    check("ras_ret_empty", 32'(ras_empty), 32'h1);

    // Return with empty stack advances sequentially
    is_ret = 1'b1; step(); is_ret = 1'b0;
    check("ras_empty_ret_pc", pc, 32'h18);
    check("ras_empty_ret_empty", 32'(ras_empty), 32'h1);

    // Five calls from 0x18: pushes 0x1C..0x2C, oldest (0x1C) overwritten
    is_call = 1'b1;
    for (int i = 0; i < 5; i++) step();
    is_call = 1'b0;
    check("ras_calls_pc", pc, 32'h2C);
    ret_exp = '{32'h2C, 32'h28, 32'h24, 32'h20, 32'h24};
    emp_exp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    is_ret = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("ras_ret%0d_pc", i), pc, ret_exp[i]);
      check($sformatf("ras_ret%0d_empty", i), 32'(ras_empty), 32'(emp_exp[i]));
    end
    is_ret = 1'b0;

    // Call+ret together replaces the top
    is_call = 1'b1; step(); is_call = 1'b0;
    check("ras_cr_setup_pc", pc, 32'h28);
    is_call = 1'b1; is_ret = 1'b1; step(); is_call = 1'b0; is_ret = 1'b0;
    check("ras_cr_pc", pc, 32'h28);
    check("ras_cr_nonempty", 32'(ras_empty), 32'h0);
    is_ret = 1'b1; step(); is_ret = 1'b0;
    check("ras_cr_ret_pc", pc, 32'h2C);
    check("ras_cr_ret_empty", 32'(ras_empty), 32'h1);

    // Call alongside redirect is not pushed; stalled call is not pushed
    is_call = 1'b1;
    redirect_to(32'h300);
    check("ras_call_redirect_pc", pc, 32'h300);
    check("ras_call_redirect_empty", 32'(ras_empty), 32'h1);
    stall = 1'b1; step(); stall = 1'b0; is_call = 1'b0;
    check("ras_call_stall_pc", pc, 32'h300);
    check("ras_call_stall_empty", 32'(ras_empty), 32'h1);
`else
    // Without the stack, call/ret are plain sequential instructions
    do_reset();
    step();
    is_call = 1'b1; step(); is_call = 1'b0;
    check("noras_call_pc", pc, 32'h4);
    check("noras_call_empty", 32'(ras_empty), 32'h1);
    is_ret = 1'b1; step(); is_ret = 1'b0;
    check("noras_ret_pc", pc, 32'h8);
    check("noras_ret_empty", 32'(ras_empty), 32'h1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
